// File: rtl/g2b_pkg.sv
// Shared constants and helpers for the Gray-to-binary stream decoder.
// Functions work on a fixed FN_W-bit container; callers zero-extend narrower words.
package g2b_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int CNT_W_DEF = 8;
    localparam int FN_W      = 64;

    localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

    // Zero-extension is harmless here: leading zeros leave the prefix XOR unchanged.
    function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
        logic [FN_W-1:0] b;
        logic            run;
        b   = '0;
        run = 1'b0;
        for (int i = FN_W - 1; i >= 0; i--) begin
            run  = run ^ g[i];
            b[i] = run;
        end
        return b;
    endfunction

    function automatic int unsigned popcount(input logic [FN_W-1:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < FN_W; i++) begin
            cnt = cnt + 32'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// Combinational Gray-to-binary decode: each binary bit is the XOR of all
// Gray bits at or above its position.
module gray2bin_comb #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        logic run;
        bin = '0;
        run = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            run    = run ^ gray[i];
            bin[i] = run;
        end
    end

endmodule

// File: rtl/gray2bin_stream.sv
// Streaming Gray-to-binary decoder with a single valid/ready register stage.
// Define G2B_STEP_CHECK_EN to build the single-bit-step checker and error counter.
module gray2bin_stream
    import g2b_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_gray,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bin,
    output logic             step_err,
    output logic [CNT_W-1:0] err_cnt
);

    logic             acc;
    logic [WIDTH-1:0] bin_p0;

    // No skid buffer: the stage frees up in the same cycle the consumer takes it.
    assign in_ready = ~out_valid | out_ready;
    assign acc      = in_valid & in_ready;

    gray2bin_comb #(
        .WIDTH(WIDTH)
    ) u_decode (
        .gray(in_gray),
        .bin (bin_p0)
    );

    // Stage p0 -> p1: output register; a held word changes only on a new accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_bin   <= '0;
        end else if (acc) begin
            out_valid <= 1'b1;
            out_bin   <= bin_p0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef G2B_STEP_CHECK_EN
    logic [WIDTH-1:0] prev_gray;
    logic             hist_vld;
    logic             step_bad_p0;

    // A repeated word has zero differing bits and counts as illegal too.
    assign step_bad_p0 = hist_vld &&
                         (popcount(FN_W'(in_gray ^ prev_gray)) != 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_gray <= '0;
            hist_vld  <= 1'b0;
            step_err  <= 1'b0;
            err_cnt   <= '0;
        end else if (acc) begin
            prev_gray <= in_gray;
            hist_vld  <= 1'b1;
            step_err  <= step_bad_p0;
            if (step_bad_p0 && (err_cnt != {CNT_W{1'b1}})) begin
                err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end
`else
    assign step_err = 1'b0;
    assign err_cnt  = '0;
`endif

endmodule
